// File: rtl/cpu_6502.sv
// cpu_6502: compact multi-cycle core running a subset of the MOS 6502 ISA.
// Cycle states T0..T3. Fetch and operand reads come from a memory that
// presents the addressed byte on data_in before the next rising edge.
// Optional build macro DECIMAL_MODE_EN: packed-BCD ADC/SBC when D=1.
module cpu_6502 #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk_in,
    input  logic        reset,
    output logic        READ_write,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic [15:0] address_out
);

    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  a_q, a_d, x_q, x_d, y_q, y_d;
    logic [7:0]  op_q, op_d, lo_q, lo_d, hi_q, hi_d;
    logic        n_q, n_d, v_q, v_d, d_q, d_d, z_q, z_d, c_q, c_d;

    logic        nz_upd;
    logic [7:0]  nz_val;
    logic        is_sub;
    logic [7:0]  operand;
    logic [9:0]  alu;
    logic [8:0]  res;
    logic        wr_cycle;

    // Binary add with carry-in; returns {carry, overflow, result}.
    function automatic logic [9:0] bin_arith(input logic [7:0] a, input logic [7:0] m,
                                             input logic cin);
        logic [8:0] sum;
        logic       ovf;
        sum = {1'b0, a} + {1'b0, m} + {8'h00, cin};
        ovf = (a[7] == m[7]) && (sum[7] != a[7]);
        return {sum[8], ovf, sum[7:0]};
    endfunction

`ifdef DECIMAL_MODE_EN
    // Packed BCD add/subtract; m is already complemented for subtract.
    // Returns {decimal carry (not-borrow for subtract), result}.
    function automatic logic [8:0] bcd_arith(input logic [7:0] a, input logic [7:0] m,
                                             input logic cin, input logic sub);
        logic [4:0] lo, hi;
        logic       lc, hc;
        lo = {1'b0, a[3:0]} + {1'b0, m[3:0]} + {4'h0, cin};
        lc = sub ? lo[4] : (lo > 5'd9);
        if (sub && !lc) lo = lo - 5'd6;
        if (!sub && lc) lo = lo + 5'd6;
        hi = {1'b0, a[7:4]} + {1'b0, m[7:4]} + {4'h0, lc};
        hc = sub ? hi[4] : (hi > 5'd9);
        if (sub && !hc) hi = hi - 5'd6;
        if (!sub && hc) hi = hi + 5'd6;
        return {hc, hi[3:0], lo[3:0]};
    endfunction
`endif

    // Bus outputs depend on registered state only (no path from data_in).
    always_comb begin
        wr_cycle    = (state_q == T3) && (op_q == 8'h8D);
        address_out = (state_q == T3) ? {hi_q, lo_q} : pc_q;
        READ_write  = !wr_cycle;
        data_out    = wr_cycle ? a_q : 8'h00;
    end

    // Sequencing, register-file and flag updates for the current cycle.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        a_d     = a_q;
        x_d     = x_q;
        y_d     = y_q;
        op_d    = op_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        n_d     = n_q;
        v_d     = v_q;
        d_d     = d_q;
        z_d     = z_q;
        c_d     = c_q;
        nz_upd  = 1'b0;
        nz_val  = 8'h00;

        // SBC and CMP add the complement; CMP always behaves as carry-in 1.
        is_sub  = (op_q == 8'hE9) || (op_q == 8'hC9);
        operand = is_sub ? ~data_in : data_in;
        alu     = bin_arith(a_q, operand, (op_q == 8'hC9) ? 1'b1 : c_q);
        res     = {alu[9], alu[7:0]};
`ifdef DECIMAL_MODE_EN
        if (d_q && (op_q != 8'hC9)) res = bcd_arith(a_q, operand, c_q, is_sub);
`endif

        case (state_q)
            T0: begin
                op_d    = data_in;
                pc_d    = pc_q + 16'd1;
                state_d = T1;
            end
            T1: begin
                state_d = T0;
                case (op_q)
                    8'h18: c_d = 1'b0;                                         // CLC
                    8'h38: c_d = 1'b1;                                         // SEC
                    8'hD8: d_d = 1'b0;                                         // CLD
                    8'hF8: d_d = 1'b1;                                         // SED
                    8'hAA: begin nz_val = a_q;         x_d = nz_val; nz_upd = 1'b1; end // TAX
                    8'h8A: begin nz_val = x_q;         a_d = nz_val; nz_upd = 1'b1; end // TXA
                    8'hA8: begin nz_val = a_q;         y_d = nz_val; nz_upd = 1'b1; end // TAY
                    8'h98: begin nz_val = y_q;         a_d = nz_val; nz_upd = 1'b1; end // TYA
                    8'hE8: begin nz_val = x_q + 8'd1;  x_d = nz_val; nz_upd = 1'b1; end // INX
                    8'hCA: begin nz_val = x_q - 8'd1;  x_d = nz_val; nz_upd = 1'b1; end // DEX
                    8'hC8: begin nz_val = y_q + 8'd1;  y_d = nz_val; nz_upd = 1'b1; end // INY
                    8'h88: begin nz_val = y_q - 8'd1;  y_d = nz_val; nz_upd = 1'b1; end // DEY
                    8'hA9, 8'hA2, 8'hA0, 8'h69, 8'hE9, 8'h29, 8'h09, 8'h49, 8'hC9: begin
                        pc_d   = pc_q + 16'd1;
                        nz_upd = 1'b1;
                        case (op_q)
                            8'hA9: begin nz_val = data_in;       a_d = nz_val; end
                            8'hA2: begin nz_val = data_in;       x_d = nz_val; end
                            8'hA0: begin nz_val = data_in;       y_d = nz_val; end
                            8'h29: begin nz_val = a_q & data_in; a_d = nz_val; end
                            8'h09: begin nz_val = a_q | data_in; a_d = nz_val; end
                            8'h49: begin nz_val = a_q ^ data_in; a_d = nz_val; end
                            8'hC9: begin nz_val = alu[7:0];      c_d = alu[9]; end
                            default: begin                      // ADC / SBC
                                nz_val = res[7:0];
                                a_d    = nz_val;
                                c_d    = res[8];
                                v_d    = alu[8];
                            end
                        endcase
                    end
                    8'hAD, 8'h8D, 8'h4C: begin                                 // absolute
                        lo_d    = data_in;
                        pc_d    = pc_q + 16'd1;
                        state_d = T2;
                    end
                    default: state_d = T0;                                     // NOP / unknown
                endcase
            end
            T2: begin
                hi_d = data_in;
                if (op_q == 8'h4C) begin
                    pc_d    = {data_in, lo_q};
                    state_d = T0;
                end else begin
                    pc_d    = pc_q + 16'd1;
                    state_d = T3;
                end
            end
            default: begin                                                     // T3
                state_d = T0;
                if (op_q == 8'hAD) begin
                    nz_val = data_in;
                    a_d    = nz_val;
                    nz_upd = 1'b1;
                end
            end
        endcase

        if (nz_upd) begin
            n_d = nz_val[7];
            z_d = (nz_val == 8'h00);
        end
    end

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= T0;
            pc_q    <= RESET_PC;
            a_q     <= 8'h00;
            x_q     <= 8'h00;
            y_q     <= 8'h00;
            op_q    <= 8'h00;
            lo_q    <= 8'h00;
            hi_q    <= 8'h00;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            d_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            x_q     <= x_d;
            y_q     <= y_d;
            op_q    <= op_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            n_q     <= n_d;
            v_q     <= v_d;
            d_q     <= d_d;
            z_q     <= z_d;
            c_q     <= c_d;
        end
    end

endmodule

// File: tb/tb_cpu_6502.sv
// Bench for cpu_6502: byte-array memory model, scoreboard of expected
// write cycles, one task per scenario.
module tb_cpu_6502;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        READ_write;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic [15:0] address_out;

    logic [7:0]  mem [0:65535];
    logic [7:0]  prog [$];
    logic [23:0] exp_q [$];
    logic [23:0] exp_w;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_in = ~clk_in;

    assign data_in = mem[address_out];

    cpu_6502 #(.RESET_PC(16'h0000)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .READ_write  (READ_write),
        .data_in     (data_in),
        .data_out    (data_out),
        .address_out (address_out)
    );

    // Assert reset, wipe memory and the scoreboard.
    task automatic hold_reset();
        @(negedge clk_in);
        reset = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        exp_q.delete();
    endtask

    task automatic load(input logic [15:0] base);
        for (int i = 0; i < prog.size(); i++) mem[base + 16'(i)] = prog[i];
    endtask

    task automatic release_reset();
        @(negedge clk_in);
        reset = 1'b1;
    endtask

    // Sample the current cycle (scoreboard any write), then advance one edge.
    task automatic step();
        if (READ_write === 1'b0) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got addr=%h data=%h, wanted no write", address_out, data_out);
            end else begin
                exp_w = exp_q.pop_front();
                if ({address_out, data_out} !== exp_w) begin
                    miscompares++;
                    $display("FAIL write: got addr=%h data=%h, wanted addr=%h data=%h",
                             address_out, data_out, exp_w[23:8], exp_w[7:0]);
                end
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic drain_check(input string name);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_pending: got %0d writes outstanding, wanted 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(posedge clk_in);
        #1;
        vectors++;
        if (address_out !== 16'h0000) begin miscompares++; $display("FAIL reset_addr: got %h wanted 0000", address_out); end
        vectors++;
        if (READ_write !== 1'b1) begin miscompares++; $display("FAIL reset_rw: got %b wanted 1", READ_write); end
        vectors++;
        if (data_out !== 8'h00) begin miscompares++; $display("FAIL reset_dout: got %h wanted 00", data_out); end
        vectors++;
        if ({dut.a_q, dut.x_q, dut.y_q} !== 24'h0) begin
            miscompares++; $display("FAIL reset_regs: got %h wanted 000000", {dut.a_q, dut.x_q, dut.y_q});
        end
        vectors++;
        if ({dut.n_q, dut.v_q, dut.d_q, dut.z_q, dut.c_q} !== 5'b0) begin
            miscompares++; $display("FAIL reset_flags: got %b wanted 00000", {dut.n_q, dut.v_q, dut.d_q, dut.z_q, dut.c_q});
        end
    endtask

    task automatic test_lda_adc_sta();
        hold_reset();
        prog = '{8'hA9, 8'h20, 8'h69, 8'h05, 8'h8D, 8'h00, 8'h02};
        load(16'h0000);
        exp_q.push_back({16'h0200, 8'h25});
        release_reset();
        repeat (7) step();
        vectors++;
        if ({READ_write, address_out, data_out} !== {1'b0, 16'h0200, 8'h25}) begin
            miscompares++;
            $display("FAIL sta_cycle4: got rw=%b addr=%h data=%h wanted rw=0 addr=0200 data=25", READ_write, address_out, data_out);
        end
        step();
        vectors++;
        if ({dut.c_q, dut.v_q} !== 2'b00) begin miscompares++; $display("FAIL adc_cv: got %b wanted 00", {dut.c_q, dut.v_q}); end
        drain_check("lda_adc_sta");
    endtask

    task automatic test_overflow();
        hold_reset();
        prog = '{8'hA9, 8'h7F, 8'h69, 8'h01, 8'h8D, 8'h00, 8'h03};
        load(16'h0000);
        exp_q.push_back({16'h0300, 8'h80});
        release_reset();
        repeat (8) step();
        vectors++;
        if ({dut.n_q, dut.v_q, dut.c_q, dut.z_q} !== 4'b1100) begin
            miscompares++; $display("FAIL ovf_nvcz: got %b wanted 1100", {dut.n_q, dut.v_q, dut.c_q, dut.z_q});
        end
        drain_check("overflow");
    endtask

    task automatic test_sbc_cmp();
        hold_reset();
        prog = '{8'h38, 8'hA9, 8'h00, 8'hE9, 8'h01, 8'h8D, 8'h01, 8'h03,
                 8'hA9, 8'h05, 8'hC9, 8'h05};
        load(16'h0000);
        exp_q.push_back({16'h0301, 8'hFF});
        release_reset();
        repeat (10) step();
        vectors++;
        if ({dut.c_q, dut.n_q} !== 2'b01) begin miscompares++; $display("FAIL sbc_cn: got %b wanted 01", {dut.c_q, dut.n_q}); end
        repeat (4) step();
        vectors++;
        if ({dut.z_q, dut.c_q, dut.n_q} !== 3'b110) begin
            miscompares++; $display("FAIL cmp_zcn: got %b wanted 110", {dut.z_q, dut.c_q, dut.n_q});
        end
        vectors++;
        if (dut.a_q !== 8'h05) begin miscompares++; $display("FAIL cmp_a: got %h wanted 05", dut.a_q); end
        drain_check("sbc_cmp");
    endtask

    task automatic test_inx_wrap();
        hold_reset();
        prog = '{8'hA2, 8'hFF, 8'hE8, 8'h8A, 8'h8D, 8'h02, 8'h03};
        load(16'h0000);
        exp_q.push_back({16'h0302, 8'h00});
        release_reset();
        repeat (10) step();
        vectors++;
        if ({dut.x_q, dut.z_q, dut.n_q} !== {8'h00, 1'b1, 1'b0}) begin
            miscompares++; $display("FAIL inx_wrap: got x=%h z=%b n=%b wanted x=00 z=1 n=0", dut.x_q, dut.z_q, dut.n_q);
        end
        drain_check("inx_wrap");
    endtask

    task automatic test_transfer_logic();
        hold_reset();
        prog = '{8'hA0, 8'h00, 8'h88, 8'h98, 8'h8D, 8'h03, 8'h03,
                 8'hAD, 8'h10, 8'h03, 8'h29, 8'h0F, 8'h09, 8'h30,
                 8'h49, 8'hFF, 8'h8D, 8'h04, 8'h03};
        load(16'h0000);
        mem[16'h0310] = 8'hA5;
        exp_q.push_back({16'h0303, 8'hFF});
        exp_q.push_back({16'h0304, 8'hCA});
        release_reset();
        repeat (13) step();
        vectors++;
        if ({READ_write, address_out} !== {1'b1, 16'h0310}) begin
            miscompares++; $display("FAIL lda_abs_bus: got rw=%b addr=%h wanted rw=1 addr=0310", READ_write, address_out);
        end
        repeat (11) step();
        vectors++;
        if ({dut.a_q, dut.y_q, dut.n_q, dut.z_q} !== {8'hCA, 8'hFF, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL logic_regs: got a=%h y=%h n=%b z=%b wanted a=CA y=FF n=1 z=0", dut.a_q, dut.y_q, dut.n_q, dut.z_q);
        end
        drain_check("transfer_logic");
    endtask

    task automatic test_back_to_back();
        hold_reset();
        prog = '{8'hA9, 8'h3C, 8'h8D, 8'h00, 8'h05, 8'h8D, 8'h01, 8'h05};
        load(16'h0000);
        exp_q.push_back({16'h0500, 8'h3C});
        exp_q.push_back({16'h0501, 8'h3C});
        release_reset();
        repeat (10) step();
        drain_check("back_to_back");
    endtask

    task automatic test_jmp_unknown();
        hold_reset();
        prog = '{8'h4C, 8'h34, 8'h12};
        load(16'h0000);
        prog = '{8'h02, 8'hA9, 8'h55, 8'h8D, 8'h10, 8'h00};
        load(16'h1234);
        exp_q.push_back({16'h0010, 8'h55});
        release_reset();
        repeat (3) step();
        vectors++;
        if ({READ_write, address_out} !== {1'b1, 16'h1234}) begin
            miscompares++; $display("FAIL jmp_target: got rw=%b addr=%h wanted rw=1 addr=1234", READ_write, address_out);
        end
        repeat (2) step();
        vectors++;
        if (address_out !== 16'h1235) begin miscompares++; $display("FAIL unknown_pc: got %h wanted 1235", address_out); end
        repeat (6) step();
        vectors++;
        if (dut.a_q !== 8'h55) begin miscompares++; $display("FAIL after_unknown_a: got %h wanted 55", dut.a_q); end
        drain_check("jmp_unknown");
    endtask

    task automatic test_reset_abort();
        hold_reset();
        prog = '{8'hA9, 8'h42, 8'h8D, 8'h00, 8'h04};
        load(16'h0000);
        release_reset();
        repeat (5) step();
        vectors++;
        if ({READ_write, address_out, data_out} !== {1'b0, 16'h0400, 8'h42}) begin
            miscompares++;
            $display("FAIL abort_pre: got rw=%b addr=%h data=%h wanted rw=0 addr=0400 data=42", READ_write, address_out, data_out);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({READ_write, address_out, data_out} !== {1'b1, 16'h0000, 8'h00}) begin
            miscompares++;
            $display("FAIL abort_bus: got rw=%b addr=%h data=%h wanted rw=1 addr=0000 data=00", READ_write, address_out, data_out);
        end
        vectors++;
        if (dut.a_q !== 8'h00) begin miscompares++; $display("FAIL abort_a: got %h wanted 00", dut.a_q); end
        @(posedge clk_in);
        #1;
        vectors++;
        if ({READ_write, address_out} !== {1'b1, 16'h0000}) begin
            miscompares++; $display("FAIL abort_hold: got rw=%b addr=%h wanted rw=1 addr=0000", READ_write, address_out);
        end
        release_reset();
        repeat (2) step();
        drain_check("reset_abort");
    endtask

    task automatic test_decimal();
        logic [7:0] want_a;
`ifdef DECIMAL_MODE_EN
        want_a = 8'h10;
`else
        want_a = 8'h0A;
`endif
        hold_reset();
        prog = '{8'hF8, 8'hA9, 8'h09, 8'h18, 8'h69, 8'h01};
        load(16'h0000);
        release_reset();
        repeat (8) step();
        vectors++;
        if ({dut.a_q, dut.d_q, dut.c_q} !== {want_a, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL decimal_adc: got a=%h d=%b c=%b wanted a=%h d=1 c=0", dut.a_q, dut.d_q, dut.c_q, want_a);
        end
        drain_check("decimal");
    endtask

    initial begin
        test_reset();
        test_lda_adc_sta();
        test_overflow();
        test_sbc_cmp();
        test_inx_wrap();
        test_transfer_logic();
        test_back_to_back();
        test_jmp_unknown();
        test_reset_abort();
        test_decimal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
